rf_sequencer: RTL

Multicycle instruction sequencer for the CPU core; it drives the register file's `do_read`, `do_write1` and `do_write2` strobes and the memory request handshakes. It steps each instruction through fetch, register read, execute, optional memory access and up to two writeback cycles. It guarantees the register file never sees two write strobes in one cycle, so the second write (e.g. base-register update) is never dropped. It also counts retired instructions and faults on memory-handshake timeouts.

---
 rtl/rf_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rf_sequencer.sv
// rf_sequencer: multicycle instruction sequencer driving register-file strobes
// and memory handshakes, with a retired-instruction counter and timeout fault.
module rf_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        is_mem,
  input  logic        cond_pass,
  input  logic        halt_inst,
  input  logic        wb2_req,
  output logic        imem_req,
  output logic        do_read,
  output logic        exec_en,
  output logic        dmem_req,
  output logic        do_write1,
  output logic        do_write2,
  output logic        inst_done,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret
);

  // Counter wide enough to hold MEM_TIMEOUT; one extra bit for the cycle-number compare.
  localparam int unsigned TW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned CW = TW + 1;
  localparam logic [CW-1:0] TLIM = CW'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, FETCH, READ, EXEC, MEM, WB1, WB2, HALT, FAULT
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] cyc_num;
  logic          timeout_hit;

  // tcnt holds cycles already spent in FETCH/MEM, so the current cycle number is tcnt+1.
  assign cyc_num     = CW'(tcnt) + CW'(1);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cyc_num == TLIM);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and instruction-end decode; the end pulse depends on the current inputs.
  always_comb begin
    state_next = state;
    inst_done  = 1'b0;
    case (state)
      IDLE:  if (run) state_next = FETCH;
      FETCH: begin
        if (imem_ack)         state_next = READ;
        else if (timeout_hit) state_next = FAULT;
      end
      READ:  state_next = EXEC;
      EXEC: begin
        if (!cond_pass) begin
          inst_done  = 1'b1;
          state_next = run ? FETCH : IDLE;
        end else if (halt_inst) begin
          state_next = HALT;
        end else if (is_mem) begin
          state_next = MEM;
        end else begin
          state_next = WB1;
        end
      end
      MEM: begin
        if (dmem_ack)         state_next = WB1;
        else if (timeout_hit) state_next = FAULT;
      end
      WB1: begin
        if (wb2_req) begin
          state_next = WB2;
        end else begin
          inst_done  = 1'b1;
          state_next = run ? FETCH : IDLE;
        end
      end
      WB2: begin
        inst_done  = 1'b1;
        state_next = run ? FETCH : IDLE;
      end
      HALT:    state_next = HALT;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // Handshake wait counter, cleared on any state change and counting while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state_next != state) begin
      tcnt <= '0;
    end else if (state == FETCH || state == MEM) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Moore strobes registered from the next state, so each is exactly its state's decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req  <= 1'b0;
      do_read   <= 1'b0;
      exec_en   <= 1'b0;
      dmem_req  <= 1'b0;
      do_write1 <= 1'b0;
      do_write2 <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      imem_req  <= (state_next == FETCH);
      do_read   <= (state_next == READ);
      exec_en   <= (state_next == EXEC);
      dmem_req  <= (state_next == MEM);
      do_write1 <= (state_next == WB1);
      do_write2 <= (state_next == WB2);
      halted    <= (state_next == HALT);
      fault     <= (state_next == FAULT);
    end
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          instret <= '0;
    else if (inst_done) instret <= instret + 32'd1;
  end

endmodule
